// File: rtl/mult_booth.sv
// Sequential radix-2 Booth signed multiplier, one recoding step per clock.
// Optional MULT_EARLY_EXIT_EN: finish early once the remaining multiplier bits can no longer add/sub.
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MULTcontrol,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] himult,
    output logic [WIDTH-1:0] lomult,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic [WIDTH:0]   acc_q,   acc_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             qm1_q,   qm1_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] himult_q, himult_d;
    logic [WIDTH-1:0] lomult_q, lomult_d;
    logic             done_q,  done_d;
    logic [WIDTH:0]   acc_sum;

`ifdef MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0]       rem_mask;
    logic                   rem_flat;
    logic [CW-1:0]          shamt;
    logic signed [2*WIDTH:0] prod_sh;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        himult_d = himult_q;
        lomult_d = lomult_q;
        done_d   = 1'b0;
        acc_sum  = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase
`ifdef MULT_EARLY_EXIT_EN
        // After cnt steps, q[WIDTH-1-cnt:0] still holds unprocessed multiplier bits.
        rem_mask = {WIDTH{1'b1}} >> cnt_q;
        rem_flat = (((q_q & rem_mask) == '0) && !qm1_q) ||
                   (((q_q | ~rem_mask) == '1) && qm1_q);
        shamt    = CW'(WIDTH) - cnt_q;
        prod_sh  = $signed({acc_q, q_q}) >>> shamt;
`endif
        case (state_q)
            IDLE: begin
                if (MULTcontrol) begin
                    mcand_d = {A[WIDTH-1], A};
                    acc_d   = '0;
                    q_d     = B;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                {acc_d, q_d, qm1_d} = {acc_sum[WIDTH], acc_sum, q_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(WIDTH)) state_d = DONE;
`ifdef MULT_EARLY_EXIT_EN
                if (rem_flat) begin
                    {acc_d, q_d} = prod_sh;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                himult_d = acc_q[WIDTH-1:0];
                lomult_d = q_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            himult_q <= '0;
            lomult_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            himult_q <= himult_d;
            lomult_q <= lomult_d;
            done_q   <= done_d;
        end
    end

    assign himult = himult_q;
    assign lomult = lomult_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: stimulus pushes expected products, a monitor pops on done.
module tb_mult_booth;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MULTcontrol = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] himult, lomult;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mult_booth #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .MULTcontrol(MULTcontrol),
        .A(A), .B(B), .himult(himult), .lomult(lomult), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("product", {himult, lomult}, e);
            end
        end
    end

    // lat_exp: required T-index of the done edge; 0 means "any, up to 33".
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat_exp, input bit pulse_mid);
        int  n;
        bit  busy_ok;
        @(negedge clock);
        A = a; B = b; MULTcontrol = 1'b1;
        exp_q.push_back(exp);
        @(posedge clock);
        #1 MULTcontrol = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
        n = 0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clock);
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (n == 10 && pulse_mid) MULTcontrol = 1'b1;
            if (n == 11) MULTcontrol = 1'b0;
            @(posedge clock);
            n++;
            if (n > 100) break;
        end
        MULTcontrol = 1'b0;
        check("busy_during_op", {63'd0, busy_ok}, 64'd1);
        if (lat_exp == 0) check("latency_bound", {63'd0, (n >= 1 && n <= 33)}, 64'd1);
        else              check("latency", 64'(n), 64'(lat_exp));
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    initial begin
        int lat_base;
        logic [31:0] ra, rb;
`ifdef MULT_EARLY_EXIT_EN
        lat_base = 0;
`else
        lat_base = 33;
`endif
        #12;
        check("rst_himult", {32'd0, himult}, 64'd0);
        check("rst_lomult", {32'd0, lomult}, 64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        check("rst_done",   {63'd0, done},   64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, lat_base, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, lat_base, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, lat_base, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, lat_base, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, lat_base, 1'b0);
`ifdef MULT_EARLY_EXIT_EN
        run_op(32'h1234_5678, 32'd0, 64'd0, 2, 1'b0);
        run_op(32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 4, 1'b0);
`else
        run_op(32'h1234_5678, 32'd0, 64'd0, 33, 1'b0);
        run_op(32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 33, 1'b0);
`endif
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            run_op(ra, rb, model(ra, rb), lat_base, 1'b0);
        end

        // Asynchronous reset mid-operation: nothing is pushed, so a done would be flagged.
        @(negedge clock);
        A = 32'd3;
`ifdef MULT_EARLY_EXIT_EN
        B = 32'h5555_5555;
`else
        B = 32'd5;
`endif
        MULTcontrol = 1'b1;
        @(posedge clock);
        #1 MULTcontrol = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_himult", {32'd0, himult}, 64'd0);
        check("arst_lomult", {32'd0, lomult}, 64'd0);
        check("arst_busy",   {63'd0, busy},   64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("arst_idle_busy", {63'd0, busy}, 64'd0);
        run_op(32'd2, 32'd2, 64'd4, lat_base, 1'b0);

        // MULTcontrol held high: second operation starts right after the first DONE.
        @(negedge clock);
        A = 32'd4; B = 32'd4; MULTcontrol = 1'b1;
        exp_q.push_back(64'd16);
        exp_q.push_back(64'd81);
        repeat (5) @(posedge clock);
        #1 A = 32'd9; B = 32'd9;
        begin
            int seen, n;
            seen = 0; n = 0;
            while (seen < 2 && n < 200) begin
                @(negedge clock);
                if (done) begin
                    seen++;
                    if (seen == 1) check("b2b_restart", {63'd0, MULTcontrol}, 64'd1);
                    if (seen == 2) MULTcontrol = 1'b0;
                end
                if (seen == 1 && !done) begin
                    check("b2b_busy_second", {63'd0, busy}, 64'd1);
                    seen = 3 - 1;
                    seen = 1 + 0;
                end
                n++;
            end
            check("b2b_two_results", 64'(seen), 64'd2);
        end
        repeat (60) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
